// File: rtl/cpu_debug_slave_jtag_host.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_slave_jtag_host
// Brief    : Virtual-JTAG initiator for the Nios II debug slave. Converts one
//            (IR, data) command into UIR/CDR/SDR/UDR/RTI strobes with a
//            divided tck and returns the word shifted in from tdo.
// Revision : 1.0  initial release
// ============================================================================
module cpu_debug_slave_jtag_host #(
    parameter int DATA_W     = 38,
    parameter int IR_W       = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IR_W-1:0]   cmd_ir,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [IR_W-1:0]   rsp_ir_out,
    output logic              busy,
    output logic              tck,
    output logic              tdi,
    input  logic              tdo,
    output logic [IR_W-1:0]   ir_in,
    input  logic [IR_W-1:0]   ir_out,
    output logic              vs_uir,
    output logic              vs_cdr,
    output logic              vs_sdr,
    output logic              vs_udr,
    output logic              jtag_state_rti
);

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int RTI_W = (RTI_CYCLES > 0) ? $clog2(RTI_CYCLES + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [RTI_W-1:0] RTI_LAST = RTI_W'((RTI_CYCLES > 0) ? RTI_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RTI  = 3'd5,
        S_RESP = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tck_q, tck_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [RTI_W-1:0]  rti_cnt_q, rti_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tdo_q, tdo_d;
    logic [IR_W-1:0]   ir_in_q, ir_in_d;
    logic [IR_W-1:0]   rsp_ir_out_q, rsp_ir_out_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              tdi_q, tdi_d;
    logic [4:0]        strobe_q, strobe_d;   // {uir, cdr, sdr, udr, rti}

    logic tck_active;
    logic tck_rise;
    logic tck_fall;

    // tck only runs while a JTAG state is in progress; rise/fall mark the clk edge that flips it
    assign tck_active = (state_q == S_UIR) || (state_q == S_CDR) || (state_q == S_SDR) ||
                        (state_q == S_UDR) || (state_q == S_RTI);
    assign tck_rise   = tck_active && (div_q == DIV_LAST) && !tck_q;
    assign tck_fall   = tck_active && (div_q == DIV_LAST) &&  tck_q;

    // Next-state logic: every JTAG state change is tied to a tck fall so strobes are stable at rises
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        tck_d        = tck_q;
        bit_cnt_d    = bit_cnt_q;
        rti_cnt_d    = rti_cnt_q;
        shreg_d      = shreg_q;
        tdo_d        = tdo_q;
        ir_in_d      = ir_in_q;
        rsp_ir_out_d = rsp_ir_out_q;
        rsp_data_d   = rsp_data_q;

        if (tck_active) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                tck_d = ~tck_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = S_UIR;
                    shreg_d = cmd_data;
                    ir_in_d = cmd_ir;
                end
            end
            S_UIR: begin
                if (tck_fall) state_d = S_CDR;
            end
            S_CDR: begin
                if (tck_rise) rsp_ir_out_d = ir_out;
                if (tck_fall) begin
                    state_d   = S_SDR;
                    bit_cnt_d = '0;
                end
            end
            S_SDR: begin
                if (tck_rise) tdo_d = tdo;
                if (tck_fall) begin
                    // Shift right so the first captured tdo bit ends up in bit 0
                    shreg_d             = shreg_q >> 1;
                    shreg_d[DATA_W-1]   = tdo_q;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_UDR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_UDR: begin
                if (tck_fall) begin
                    rti_cnt_d = '0;
                    state_d   = (RTI_CYCLES == 0) ? S_RESP : S_RTI;
                end
            end
            S_RTI: begin
                if (tck_fall) begin
                    if (rti_cnt_q == RTI_LAST) begin
                        rti_cnt_d = '0;
                        state_d   = S_RESP;
                    end else begin
                        rti_cnt_d = rti_cnt_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                // The first RESP cycle latches the result; rsp_valid follows one clk later
                if (!rsp_valid_q) rsp_data_d = shreg_q;
                if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rsp_valid_d = (state_q == S_RESP) && (state_d == S_RESP);
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        tdi_d       = (state_d == S_SDR) ? shreg_d[0] : 1'b0;
        strobe_d    = {state_d == S_UIR, state_d == S_CDR, state_d == S_SDR,
                       state_d == S_UDR, state_d == S_RTI};
    end

    // State and registered outputs; reset drops any in-flight command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            tck_q        <= 1'b0;
            bit_cnt_q    <= '0;
            rti_cnt_q    <= '0;
            shreg_q      <= '0;
            tdo_q        <= 1'b0;
            ir_in_q      <= '0;
            rsp_ir_out_q <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            tdi_q        <= 1'b0;
            strobe_q     <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            tck_q        <= tck_d;
            bit_cnt_q    <= bit_cnt_d;
            rti_cnt_q    <= rti_cnt_d;
            shreg_q      <= shreg_d;
            tdo_q        <= tdo_d;
            ir_in_q      <= ir_in_d;
            rsp_ir_out_q <= rsp_ir_out_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            tdi_q        <= tdi_d;
            strobe_q     <= strobe_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_ir_out     = rsp_ir_out_q;
    assign busy           = busy_q;
    assign tck            = tck_q;
    assign tdi            = tdi_q;
    assign ir_in          = ir_in_q;
    assign vs_uir         = strobe_q[4];
    assign vs_cdr         = strobe_q[3];
    assign vs_sdr         = strobe_q[2];
    assign vs_udr         = strobe_q[1];
    assign jtag_state_rti = strobe_q[0];

endmodule
`default_nettype wire

// File: tb/tb_cpu_debug_slave_jtag_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_debug_slave_jtag_host
// Brief    : Scoreboard bench for cpu_debug_slave_jtag_host. Default instance
//            plus a TCK_DIV=1 / RTI_CYCLES=0 instance, each with a 38-bit
//            debug-slave shift register model on tck.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_debug_slave_jtag_host;

    localparam int DW  = 38;
    localparam int IRW = 2;
    localparam logic [DW-1:0] CAP1 = 38'h2A_5555_AAAA;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [IRW-1:0] irout;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    // Edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- default instance ----------------
    logic            reset_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [IRW-1:0]  cmd_ir, rsp_ir_out, ir_in, ir_out;
    logic [DW-1:0]   cmd_data, rsp_data;
    logic            tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

    cpu_debug_slave_jtag_host dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .busy(busy), .tck(tck), .tdi(tdi),
        .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti)
    );

    // ---------------- fast instance ----------------
    logic            reset_n2, cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, busy2;
    logic [IRW-1:0]  cmd_ir2, rsp_ir_out2, ir_in2, ir_out2;
    logic [DW-1:0]   cmd_data2, rsp_data2;
    logic            tck2, tdi2, tdo2, vs_uir2, vs_cdr2, vs_sdr2, vs_udr2, rti2;

    cpu_debug_slave_jtag_host #(.DATA_W(DW), .IR_W(IRW), .TCK_DIV(1), .RTI_CYCLES(0)) dut2 (
        .clk(clk), .reset_n(reset_n2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_ir(cmd_ir2), .cmd_data(cmd_data2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_data(rsp_data2), .rsp_ir_out(rsp_ir_out2), .busy(busy2), .tck(tck2), .tdi(tdi2),
        .tdo(tdo2), .ir_in(ir_in2), .ir_out(ir_out2), .vs_uir(vs_uir2), .vs_cdr(vs_cdr2),
        .vs_sdr(vs_sdr2), .vs_udr(vs_udr2), .jtag_state_rti(rti2)
    );

    // ---------------- slave model 1 ----------------
    logic [DW-1:0] sr1 = '0;
    logic [DW-1:0] udr_sr1 = '0;
    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
    assign tdo = sr1[0];

    // Debug-slave shift register on tck, plus tck-rise counts per strobe
    always @(posedge tck) begin
        if (vs_cdr)      sr1 <= CAP1;
        else if (vs_sdr) sr1 <= {tdi, sr1[DW-1:1]};
        if (vs_udr)      udr_sr1 <= sr1;
        if (vs_uir)         n_uir++;
        if (vs_cdr)         n_cdr++;
        if (vs_sdr)         n_sdr++;
        if (vs_udr)         n_udr++;
        if (jtag_state_rti) n_rti++;
    end

    // ---------------- slave model 2 ----------------
    logic [DW-1:0] cap_tab [4] = '{38'h3A_0000_00FF, 38'h01_2345_6789, 38'h20_0000_0000, 38'h15_5AA5_C33C};
    logic [DW-1:0] d_tab   [4] = '{38'h00_0000_0001, 38'h3F_FFFF_FFFF, 38'h2B_CDEF_0123, 38'h10_8421_8421};
    logic [IRW-1:0] ir_tab [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    logic [DW-1:0] sr2 = '0;
    int ncap2 = 0;
    logic [DW+IRW-1:0] udq2 [$];
    assign tdo2    = sr2[0];
    assign ir_out2 = 2'b10;

    // Fast-instance slave: per-command capture value, checks shifted-in word and IR at UDR
    always @(posedge tck2) begin
        logic [DW+IRW-1:0] e;
        if (vs_cdr2) begin
            sr2 <= cap_tab[ncap2 % 4];
            ncap2++;
        end else if (vs_sdr2) begin
            sr2 <= {tdi2, sr2[DW-1:1]};
        end
        if (vs_udr2) begin
            if (udq2.size() == 0) begin
                check("udr2_unexpected", 1, 0);
            end else begin
                e = udq2.pop_front();
                check("udr2_sr", sr2, e[DW+IRW-1:IRW]);
                check("udr2_ir_in", ir_in2, e[IRW-1:0]);
            end
        end
    end

    // ---------------- scoreboards / monitors ----------------
    rsp_t sb1 [$];
    rsp_t sb2 [$];
    int   acc1 = 0, acc2 = 0, acc_cnt1 = 0;
    logic rv_prev1 = 1'b0, rv_prev2 = 1'b0;

    // Monitor 1: accept tracking, latency on rsp_valid rise, data compare on handshake
    always @(negedge clk) begin
        rsp_t e;
        if (reset_n && cmd_valid && cmd_ready) begin
            acc1 = cyc + 1;
            acc_cnt1++;
        end
        if (reset_n && rsp_valid && !rv_prev1) check("lat1", cyc - acc1, 173);
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb1.size() == 0) begin
                check("rsp1_unexpected", 1, 0);
            end else begin
                e = sb1.pop_front();
                check("rsp1_data", rsp_data, e.data);
                check("rsp1_ir_out", rsp_ir_out, e.irout);
            end
        end
        rv_prev1 = rsp_valid;
    end

    // Monitor 2: same checks for the fast instance
    always @(negedge clk) begin
        rsp_t e;
        if (reset_n2 && cmd_valid2 && cmd_ready2) acc2 = cyc + 1;
        if (reset_n2 && rsp_valid2 && !rv_prev2) check("lat2", cyc - acc2, 83);
        if (reset_n2 && rsp_valid2 && rsp_ready2) begin
            if (sb2.size() == 0) begin
                check("rsp2_unexpected", 1, 0);
            end else begin
                e = sb2.pop_front();
                check("rsp2_data", rsp_data2, e.data);
                check("rsp2_ir_out", rsp_ir_out2, e.irout);
            end
        end
        rv_prev2 = rsp_valid2;
    end

    // Strobe stability: no strobe change in the clk sample of, before, or after a tck rise
    logic       stab_en = 1'b0;
    logic [4:0] sv_prev = '0;
    logic       tck_prev = 1'b0, rise_prev = 1'b0, chg_prev = 1'b0;
    int         viol = 0;
    always @(negedge clk) begin
        logic [4:0] sv;
        logic       rise_now, chg_now;
        sv       = {vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti};
        rise_now = tck && !tck_prev;
        chg_now  = (sv != sv_prev);
        if (stab_en && ((chg_now && (rise_now || rise_prev)) || (rise_now && chg_prev))) viol++;
        sv_prev   = sv;
        tck_prev  = tck;
        rise_prev = rise_now;
        chg_prev  = chg_now;
    end

    // ---------------- helpers ----------------
    task automatic check_reset1(input string tag);
        check({tag, "_strobes"}, {vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}, 0);
        check({tag, "_tck"}, tck, 0);
        check({tag, "_tdi"}, tdi, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ir_in"}, ir_in, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
    endtask

    task automatic wait_ready1(input string tag);
        int t = 0;
        while (!cmd_ready && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        check({tag, "_ready_seen"}, cmd_ready, 1);
    endtask

    task automatic wait_rsp1(input string tag);
        int t = 0;
        while (!rsp_valid && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        check({tag, "_rsp_seen"}, rsp_valid, 1);
    endtask

    // Present one command for exactly one accepting edge; expected response queued at issue
    task automatic issue1(input logic [IRW-1:0] ir, input logic [DW-1:0] d,
                          input logic [IRW-1:0] iro, input string tag);
        wait_ready1(tag);
        ir_out    = iro;
        cmd_ir    = ir;
        cmd_data  = d;
        cmd_valid = 1'b1;
        sb1.push_back({CAP1, iro});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        int t;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b1; ir_out = '0;
        reset_n2 = 1'b0; cmd_valid2 = 1'b0; cmd_ir2 = '0; cmd_data2 = '0; rsp_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset1("por");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic transfer with timing: rise counts per strobe, latency, strobe stability
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
        stab_en = 1'b1;
        issue1(2'b10, 38'h15_0F0F_F0F0, 2'b01, "t2");
        wait_rsp1("t2");
        @(posedge clk); #1;
        stab_en = 1'b0;
        check("t2_udr_sr", udr_sr1, 38'h15_0F0F_F0F0);
        check("t2_ir_in", ir_in, 2'b10);
        check("t3_uir_rises", n_uir, 1);
        check("t3_cdr_rises", n_cdr, 1);
        check("t3_sdr_rises", n_sdr, 38);
        check("t3_udr_rises", n_udr, 1);
        check("t3_rti_rises", n_rti, 2);
        check("t3_strobe_stability_violations", viol, 0);
        check("t2_idle_after", cmd_ready, 1);

        // Reset while idle with a non-zero ir_in held
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset1("t1");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Backpressure: response held, further commands ignored
        rsp_ready = 1'b0;
        issue1(2'b01, 38'h3F_0000_FFFF, 2'b11, "t4a");
        wait_rsp1("t4a");
        cmd_ir = 2'b11; cmd_data = 38'h05_A5A5_5A5A; cmd_valid = 1'b1;
        t = acc_cnt1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_data", rsp_data, CAP1);
            check("t4_hold_cmd_ready", cmd_ready, 0);
        end
        check("t4_no_accept", acc_cnt1, t);
        sb1.push_back({CAP1, 2'b11});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_idle_ready", cmd_ready, 1);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_valid", rsp_valid, 0);
        @(posedge clk); #1;
        check("t4_accept_busy", busy, 1);
        check("t4_accept_count", acc_cnt1, t + 1);
        cmd_valid = 1'b0;
        wait_rsp1("t4b");
        @(posedge clk); #1;
        check("t4b_udr_sr", udr_sr1, 38'h05_A5A5_5A5A);

        // Reset after 10 SDR bits: command dropped, then a clean command
        n_sdr = 0;
        issue1(2'b11, 38'h2F_1234_5678, 2'b10, "t5a");
        t = 0;
        while (n_sdr < 10 && t < 500) begin
            @(posedge clk); #1; t++;
        end
        check("t5_sdr_reached", n_sdr, 10);
        reset_n = 1'b0;
        sb1.delete();
        #1 check_reset1("t5");
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("t5_no_rsp", seen, 0);
        issue1(2'b01, 38'h00_DEAD_BEEF, 2'b01, "t5b");
        wait_rsp1("t5b");
        @(posedge clk); #1;
        check("t5b_udr_sr", udr_sr1, 38'h00_DEAD_BEEF);
        check("t5b_ir_in", ir_in, 2'b01);

        // Fast instance, cmd_valid/rsp_ready held high, back-to-back commands
        reset_n2   = 1'b1;
        cmd_valid2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_ir2   = ir_tab[k];
            cmd_data2 = d_tab[k];
            sb2.push_back({cap_tab[k], 2'b10});
            udq2.push_back({d_tab[k], ir_tab[k]});
            t = 0;
            while (!cmd_ready2 && t < 500) begin
                @(posedge clk); #1; t++;
            end
            check("t6_ready_seen", cmd_ready2, 1);
            @(posedge clk); #1;
        end
        cmd_valid2 = 1'b0;
        t = 0;
        while (sb2.size() != 0 && t < 500) begin
            @(posedge clk); #1; t++;
        end
        check("t6_all_responses", sb2.size(), 0);
        check("t6_all_udr", udq2.size(), 0);
        check("t6_captures", ncap2, 4);
        check("sb1_drained", sb1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
